// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
// Module      : me_pkg
// Description : Shared geometry and types for the motion-estimation
//               reference-pixel buffer banks.
// Revision    : 1.0 - initial release
// ============================================================================
package me_pkg;

    localparam int PIXEL       = 8;
    localparam int PIX_PER_ROW = 8;
    localparam int ROW_W       = PIXEL * PIX_PER_ROW;
    localparam int BANK_DEPTH  = 96;
    localparam int BANK_AW     = 7;

    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [BANK_AW-1:0] bank_addr_t;

    // True when an address falls inside the populated rows of a bank
    function automatic logic addr_in_range(input bank_addr_t a);
        return (a < BANK_AW'(BANK_DEPTH));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ref_pixel_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : ref_pixel_bank_if
// Description : Fill/read port bundle of one reference-pixel bank.
//               The master fills rows and requests reads; the slave
//               (the bank) returns registered row data.
// Revision    : 1.0 - initial release
// ============================================================================
interface ref_pixel_bank_if;
    import me_pkg::*;

    row_t       ref_in;
    logic       Bank_sel;
    bank_addr_t address;
    bank_addr_t write_address;
    logic       rd_en;
    row_t       ref_ou;

    modport master (
        output ref_in,
        output Bank_sel,
        output address,
        output write_address,
        output rd_en,
        input  ref_ou
    );

    modport slave (
        input  ref_in,
        input  Bank_sel,
        input  address,
        input  write_address,
        input  rd_en,
        output ref_ou
    );

endinterface
`default_nettype wire

// File: rtl/bank_dpram.sv
`default_nettype none
// ============================================================================
// Module      : bank_dpram
// Description : Synchronous 1W/1R register array with synchronous clear.
//               Read data is the current (pre-write) row content, so a
//               registered consumer sees read-first behaviour on collisions.
//               Out-of-range writes are dropped here.
// Revision    : 1.0 - initial release
// ============================================================================
module bank_dpram
    import me_pkg::*;
(
    input  wire        clk,
    input  wire        rst_n,    // active-high synchronous clear
    input  wire        wr_req,
    input  bank_addr_t waddr,
    input  row_t       wdata,
    input  bank_addr_t raddr,
    output row_t       rdata
);

    row_t r_mem [BANK_DEPTH];
    logic w_we;

    // Write only lands when requested and the row exists
    assign w_we = wr_req && addr_in_range(waddr);

    // Row storage: clear on reset, otherwise single-port write
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < BANK_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the stored row; out-of-range returns zero
    always_comb begin
        rdata = '0;
        if (addr_in_range(raddr)) begin
            rdata = r_mem[raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ref_pixel_bank.sv
`default_nettype none
// ============================================================================
// Module      : ref_pixel_bank
// Description : One bank of the HEVC ME reference-pixel buffer. Port B fills
//               rows while the bank is selected for fill (Bank_sel == 0);
//               port A reads rows to the PE array through an output register
//               with one cycle of latency. rd_en is active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module ref_pixel_bank
    import me_pkg::*;
(
    input  wire              clk,
    input  wire              rst_n,   // active-high synchronous reset
    ref_pixel_bank_if.slave  bus
);

    logic w_wr_req;
    logic w_rd_fire;
    row_t w_rdata;
    row_t r_ref_ou;

    // Fill is allowed only while this bank is in fill mode
    assign w_wr_req  = ~bus.Bank_sel;
    // Read enable is active-low and independent of fill mode
    assign w_rd_fire = ~bus.rd_en;

    bank_dpram u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_req (w_wr_req),
        .waddr  (bus.write_address),
        .wdata  (bus.ref_in),
        .raddr  (bus.address),
        .rdata  (w_rdata)
    );

    // Output register: load on read, zero for missing rows, hold otherwise
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_ref_ou <= '0;
        end else if (w_rd_fire) begin
            r_ref_ou <= addr_in_range(bus.address) ? w_rdata : '0;
        end
    end

    assign bus.ref_ou = r_ref_ou;

endmodule
`default_nettype wire

// File: tb/tb_ref_pixel_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ref_pixel_bank
// Description : Directed self-checking bench for ref_pixel_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ref_pixel_bank;

    typedef struct {
        logic        rst;
        logic        bank_sel;
        logic [6:0]  waddr;
        logic [63:0] wdata;
        logic        rd_en;
        logic [6:0]  addr;
        logic [63:0] exp_ou;
        string       name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    ref_pixel_bank_if bus ();

    ref_pixel_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] P0F = {8{8'h0F}};
    localparam logic [63:0] P55 = {8{8'h55}};
    localparam logic [63:0] P33 = {8{8'h33}};
    localparam logic [63:0] PFF = {8{8'hFF}};
    localparam logic [63:0] PAA = {8{8'hAA}};
    localparam logic [63:0] PC3 = {8{8'hC3}};
    localparam logic [63:0] P12 = 64'h1234_5678_9ABC_DEF0;

    task automatic add(input logic rst, input logic bs, input logic [6:0] wa,
                       input logic [63:0] wd, input logic re, input logic [6:0] a,
                       input logic [63:0] e, input string n);
        vec_t v;
        v.rst = rst; v.bank_sel = bs; v.waddr = wa; v.wdata = wd;
        v.rd_en = re; v.addr = a; v.exp_ou = e; v.name = n;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge pass, then compare
    task automatic step(input logic rst, input logic bs, input logic [6:0] wa,
                        input logic [63:0] wd, input logic re, input logic [6:0] a,
                        input logic [63:0] e, input string n);
        rst_n             = rst;
        bus.Bank_sel      = bs;
        bus.write_address = wa;
        bus.ref_in        = wd;
        bus.rd_en         = re;
        bus.address       = a;
        @(posedge clk);
        #1;
        checks++;
        if (bus.ref_ou !== e) begin
            errors++;
            $display("FAIL %s: ref_ou=%h expected=%h", n, bus.ref_ou, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        bus.Bank_sel = 1'b1;
        bus.write_address = '0;
        bus.ref_in = '0;
        bus.rd_en = 1'b1;
        bus.address = '0;

        // Reset, then empty reads
        add(1, 1, 0, 0,   1, 0, 0, "reset");
        for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 7'(i), 0, "rd_after_reset");
        // Fill rows 0, 1, 3 for three cycles each (reads disabled, output holds 0)
        for (int i = 0; i < 3; i++) add(0, 0, 0, P0F, 1, 0, 0, "fill_row0");
        for (int i = 0; i < 3; i++) add(0, 0, 1, P55, 1, 0, 0, "fill_row1");
        for (int i = 0; i < 3; i++) add(0, 0, 3, P33, 1, 0, 0, "fill_row3");
        // Read back
        add(0, 1, 0, 0, 0, 0, P0F, "rd_row0");
        add(0, 1, 0, 0, 0, 1, P55, "rd_row1");
        add(0, 1, 0, 0, 0, 2, 0,   "rd_row2");
        add(0, 1, 0, 0, 0, 3, P33, "rd_row3");
        // Blocked write while Bank_sel=1
        add(0, 1, 0, PFF, 1, 0, P33, "blocked_wr_hold");
        add(0, 1, 0, 0,   0, 0, P0F, "blocked_wr_rd0");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].bank_sel, vecs[i].waddr, vecs[i].wdata,
                 vecs[i].rd_en, vecs[i].addr, vecs[i].exp_ou, vecs[i].name);
        end

        // Same-cycle collision is read-first
        step(0, 0, 1, PAA, 0, 1, P55, "collide_old");
        step(0, 1, 0, 0,   0, 1, PAA, "collide_new");

        // rd_en high: output holds while address moves
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 7'(i), PAA, "rd_hold");

        // Out-of-range write and read
        step(0, 0, 100, P12, 0, 100, 0, "oor_read");
        step(0, 1, 0, 0, 0, 36, 0,   "oor_no_alias");
        step(0, 1, 0, 0, 0, 0,  P0F, "oor_row0");
        step(0, 1, 0, 0, 0, 1,  PAA, "oor_row1");
        step(0, 1, 0, 0, 0, 3,  P33, "oor_row3");

        // Last valid row
        step(0, 0, 95, PC3, 1, 0, P33, "fill_row95");
        step(0, 1, 0, 0, 0, 95, PC3, "rd_row95");

        // Reset mid-stream clears output and content
        step(1, 1, 0, 0, 0, 1,  0, "midrst_ou");
        step(0, 1, 0, 0, 0, 1,  0, "midrst_row1");
        step(0, 1, 0, 0, 0, 95, 0, "midrst_row95");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
